// File: rtl/core_lsu_pkg.sv
// core_lsu_pkg: state encoding, funct3 access-size codes and the access byte-count
// helper shared by the load/store unit and its alignment datapath.
package core_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  localparam logic [2:0] LSU_SZ_B  = 3'b000;
  localparam logic [2:0] LSU_SZ_H  = 3'b001;
  localparam logic [2:0] LSU_SZ_W  = 3'b010;
  localparam logic [2:0] LSU_SZ_D  = 3'b011;
  localparam logic [2:0] LSU_SZ_BU = 3'b100;
  localparam logic [2:0] LSU_SZ_HU = 3'b101;
  localparam logic [2:0] LSU_SZ_WU = 3'b110;

  function automatic logic [3:0] lsu_bytes(input logic [2:0] size);
    case (size)
      LSU_SZ_B, LSU_SZ_BU: lsu_bytes = 4'd1;
      LSU_SZ_H, LSU_SZ_HU: lsu_bytes = 4'd2;
      LSU_SZ_W, LSU_SZ_WU: lsu_bytes = 4'd4;
      default:             lsu_bytes = 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/core_lsu_align.sv
// core_lsu_align: combinational byte-lane logic -- request fault check, byte enables,
// store lane shift, and load extract with sign/zero extension.
module core_lsu_align
  import core_lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                req_size,
  input  logic                      req_we,
  input  logic [$clog2(XLEN/8)-1:0] req_off,
  input  logic [XLEN-1:0]           req_wdata,
  input  logic [2:0]                ld_size,
  input  logic [$clog2(XLEN/8)-1:0] ld_off,
  input  logic [XLEN-1:0]           mem_rdata,
  output logic                      req_fault,
  output logic [XLEN/8-1:0]         st_be,
  output logic [XLEN-1:0]           st_wdata,
  output logic [XLEN-1:0]           ld_data
);

  localparam int BW    = XLEN / 8;
  localparam int OFF_W = $clog2(BW);

  logic            illegal;
  logic            misal;
  logic [7:0]      mask8;
  logic [XLEN-1:0] shifted;

  always_comb begin
    illegal   = (req_size == 3'b111) || (req_we && req_size[2]) ||
                ((XLEN == 32) && ((req_size == LSU_SZ_D) || (req_size == LSU_SZ_WU)));
    misal     = |(req_off & OFF_W'(lsu_bytes(req_size) - 4'd1));
    req_fault = illegal || misal;
  end

  always_comb begin
    case (req_size[1:0])
      2'b00:   mask8 = 8'h01;
      2'b01:   mask8 = 8'h03;
      2'b10:   mask8 = 8'h0F;
      default: mask8 = 8'hFF;
    endcase
    st_be    = BW'(mask8) << req_off;
    st_wdata = req_wdata << {req_off, 3'b000};
  end

  // Size casts of a $signed operand sign-extend, which covers W at both XLEN values.
  always_comb begin
    shifted = mem_rdata >> {ld_off, 3'b000};
    case (ld_size[1:0])
      2'b00: begin
        if (ld_size[2]) ld_data = XLEN'(shifted[7:0]);
        else            ld_data = XLEN'($signed(shifted[7:0]));
      end
      2'b01: begin
        if (ld_size[2]) ld_data = XLEN'(shifted[15:0]);
        else            ld_data = XLEN'($signed(shifted[15:0]));
      end
      2'b10: begin
        if (ld_size[2]) ld_data = XLEN'(shifted[31:0]);
        else            ld_data = XLEN'($signed(shifted[31:0]));
      end
      default: ld_data = shifted;
    endcase
  end

endmodule

// File: rtl/core_lsu.sv
// core_lsu: request/acknowledge load/store unit with wait-state tolerance and fault reporting.
// Optional bus timeout is enabled by defining CORE_LSU_TIMEOUT_EN.
module core_lsu
  import core_lsu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [4:0]        req_rd,
  output logic              resp_valid,
  output logic [4:0]        resp_rd,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int BW    = XLEN / 8;
  localparam int OFF_W = $clog2(BW);

  lsu_state_t        state_q, state_d;
  logic              mem_we_q, mem_we_d;
  logic [BW-1:0]     mem_be_q, mem_be_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [2:0]        size_q, size_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [4:0]        rd_q, rd_d;
  logic [4:0]        resp_rd_q, resp_rd_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic              accept;
  logic              req_fault;
  logic              timeout;
  logic [BW-1:0]     al_be;
  logic [XLEN-1:0]   al_wdata;
  logic [XLEN-1:0]   al_ld;

  core_lsu_align #(
    .XLEN(XLEN)
  ) u_align (
    .req_size (req_size),
    .req_we   (req_we),
    .req_off  (req_addr[OFF_W-1:0]),
    .req_wdata(req_wdata),
    .ld_size  (size_q),
    .ld_off   (off_q),
    .mem_rdata(mem_rdata),
    .req_fault(req_fault),
    .st_be    (al_be),
    .st_wdata (al_wdata),
    .ld_data  (al_ld)
  );

  assign req_ready  = (state_q == IDLE) || (state_q == RESP);
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == RESP);
  assign mem_req    = (state_q == BUS);
  assign busy       = (state_q == BUS) || (req_valid && !req_ready);

  assign mem_we     = mem_we_q;
  assign mem_be     = mem_be_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_rd    = resp_rd_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

`ifdef CORE_LSU_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept)                cnt_d = '0;
    else if (state_q == BUS)   cnt_d = cnt_q + 1'b1;
  end

  // Fires on the last permitted BUS cycle so mem_req is high for exactly TIMEOUT_CYC cycles.
  assign timeout = (state_q == BUS) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign timeout            = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    mem_we_d     = mem_we_q;
    mem_be_d     = mem_be_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    size_d       = size_q;
    off_d        = off_q;
    rd_d         = rd_q;
    resp_rd_d    = resp_rd_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          size_d = req_size;
          off_d  = req_addr[OFF_W-1:0];
          rd_d   = req_rd;
          if (req_fault) begin
            state_d      = RESP;
            resp_rd_d    = req_rd;
            resp_rdata_d = '0;
            resp_err_d   = 1'b1;
          end else begin
            state_d     = BUS;
            mem_we_d    = req_we;
            mem_be_d    = al_be;
            mem_addr_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_wdata_d = al_wdata;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUS: begin
        if (mem_ack) begin
          state_d      = RESP;
          resp_rd_d    = rd_q;
          resp_rdata_d = mem_we_q ? '0 : al_ld;
          resp_err_d   = 1'b0;
        end else if (timeout) begin
          state_d      = RESP;
          resp_rd_d    = rd_q;
          resp_rdata_d = '0;
          resp_err_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mem_we_q     <= 1'b0;
      mem_be_q     <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_rd_q    <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_we_q     <= mem_we_d;
      mem_be_q     <= mem_be_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_rd_q    <= resp_rd_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Latched request attributes are only consulted while an access is live.
  always_ff @(posedge clk) begin
    size_q <= size_d;
    off_q  <= off_d;
    rd_q   <= rd_d;
  end

endmodule

// File: tb/tb_core_lsu.sv
// tb_core_lsu: directed bench for core_lsu with a 32-bit instance (timeout 8) and a 64-bit instance.
module tb_core_lsu;
  import core_lsu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_tests = 0;
  int n_fail  = 0;

  logic        a_req_valid, a_req_ready, a_req_we, a_resp_valid, a_resp_err, a_busy;
  logic        a_mem_req, a_mem_we, a_mem_ack;
  logic [2:0]  a_req_size;
  logic [4:0]  a_req_rd, a_resp_rd;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0]  a_mem_be;

  logic        b_req_valid, b_req_ready, b_req_we, b_resp_valid, b_resp_err, b_busy;
  logic        b_mem_req, b_mem_we, b_mem_ack;
  logic [2:0]  b_req_size;
  logic [4:0]  b_req_rd, b_resp_rd;
  logic [31:0] b_req_addr, b_mem_addr;
  logic [63:0] b_req_wdata, b_resp_rdata, b_mem_wdata, b_mem_rdata;
  logic [7:0]  b_mem_be;

  core_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT_CYC(8)) u_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_size(a_req_size), .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_rd(a_req_rd),
    .resp_valid(a_resp_valid), .resp_rd(a_resp_rd), .resp_rdata(a_resp_rdata),
    .resp_err(a_resp_err), .busy(a_busy),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_be(a_mem_be), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_ack(a_mem_ack), .mem_rdata(a_mem_rdata)
  );

  core_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT_CYC(8)) u_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_size(b_req_size), .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_rd(b_req_rd),
    .resp_valid(b_resp_valid), .resp_rd(b_resp_rd), .resp_rdata(b_resp_rdata),
    .resp_err(b_resp_err), .busy(b_busy),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_ack(b_mem_ack), .mem_rdata(b_mem_rdata)
  );

  typedef struct packed {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vt[14];

  function automatic vec_t mk(input logic we, input logic [2:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata, input logic err,
                              input logic [31:0] e_addr, input logic [3:0] e_be,
                              input logic [31:0] e_wdata, input logic [31:0] e_rdata);
    vec_t v;
    v.we = we; v.size = size; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.err = err;
    v.e_addr = e_addr; v.e_be = e_be; v.e_wdata = e_wdata; v.e_rdata = e_rdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_a(input vec_t v, input int idx);
    a_req_valid = 1'b1; a_req_we = v.we; a_req_size = v.size;
    a_req_addr = v.addr; a_req_wdata = v.wdata; a_req_rd = 5'(idx + 1);
    chk($sformatf("v%0d_ready", idx), a_req_ready, 1);
    tick();
    a_req_valid = 1'b0;
    if (v.err) begin
      chk($sformatf("v%0d_errvalid", idx), a_resp_valid, 1);
      chk($sformatf("v%0d_err", idx), a_resp_err, 1);
      chk($sformatf("v%0d_nomemreq", idx), a_mem_req, 0);
      chk($sformatf("v%0d_errdata", idx), a_resp_rdata, 0);
      chk($sformatf("v%0d_errrd", idx), a_resp_rd, 5'(idx + 1));
    end else begin
      chk($sformatf("v%0d_memreq", idx), a_mem_req, 1);
      chk($sformatf("v%0d_busy", idx), a_busy, 1);
      chk($sformatf("v%0d_addr", idx), a_mem_addr, v.e_addr);
      chk($sformatf("v%0d_be", idx), a_mem_be, v.e_be);
      chk($sformatf("v%0d_we", idx), a_mem_we, v.we);
      if (v.we) chk($sformatf("v%0d_wdata", idx), a_mem_wdata, v.e_wdata);
      a_mem_ack = 1'b1; a_mem_rdata = v.rdata;
      tick();
      a_mem_ack = 1'b0;
      chk($sformatf("v%0d_valid", idx), a_resp_valid, 1);
      chk($sformatf("v%0d_err", idx), a_resp_err, 0);
      chk($sformatf("v%0d_rdata", idx), a_resp_rdata, v.e_rdata);
      chk($sformatf("v%0d_rd", idx), a_resp_rd, 5'(idx + 1));
    end
    tick();
    chk($sformatf("v%0d_pulse_end", idx), a_resp_valid, 0);
  endtask

  task automatic acc_b(input string nm, input logic we, input logic [2:0] size,
                       input logic [31:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                       input logic err, input logic [31:0] e_addr, input logic [7:0] e_be,
                       input logic [63:0] e_wdata, input logic [63:0] e_rdata);
    b_req_valid = 1'b1; b_req_we = we; b_req_size = size;
    b_req_addr = addr; b_req_wdata = wdata; b_req_rd = 5'd21;
    tick();
    b_req_valid = 1'b0;
    if (err) begin
      chk({nm, "_err"}, b_resp_err, 1);
      chk({nm, "_nomemreq"}, b_mem_req, 0);
    end else begin
      chk({nm, "_memreq"}, b_mem_req, 1);
      chk({nm, "_addr"}, b_mem_addr, e_addr);
      chk({nm, "_be"}, b_mem_be, e_be);
      if (we) chk({nm, "_wdata"}, b_mem_wdata, e_wdata);
      b_mem_ack = 1'b1; b_mem_rdata = rdata;
      tick();
      b_mem_ack = 1'b0;
      chk({nm, "_err"}, b_resp_err, 0);
      chk({nm, "_rdata"}, b_resp_rdata, e_rdata);
      chk({nm, "_rd"}, b_resp_rd, 21);
    end
    chk({nm, "_valid"}, b_resp_valid, 1);
    tick();
    chk({nm, "_pulse_end"}, b_resp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst = 1'b1;
    a_req_valid = 0; a_req_we = 0; a_req_size = 0; a_req_addr = 0; a_req_wdata = 0; a_req_rd = 0;
    a_mem_ack = 0; a_mem_rdata = 0;
    b_req_valid = 0; b_req_we = 0; b_req_size = 0; b_req_addr = 0; b_req_wdata = 0; b_req_rd = 0;
    b_mem_ack = 0; b_mem_rdata = 0;

    vt[0]  = mk(1, LSU_SZ_B,  32'h1003, 32'h000000AB, 32'h0,        0, 32'h1000, 4'b1000, 32'hAB000000, 32'h0);
    vt[1]  = mk(0, LSU_SZ_B,  32'h1001, 32'h0,        32'h00008000, 0, 32'h1000, 4'b0010, 32'h0,        32'hFFFFFF80);
    vt[2]  = mk(0, LSU_SZ_BU, 32'h1001, 32'h0,        32'h00008000, 0, 32'h1000, 4'b0010, 32'h0,        32'h00000080);
    vt[3]  = mk(0, LSU_SZ_W,  32'h1002, 32'h0,        32'h0,        1, 32'h0,    4'b0000, 32'h0,        32'h0);
    vt[4]  = mk(0, LSU_SZ_D,  32'h1000, 32'h0,        32'h0,        1, 32'h0,    4'b0000, 32'h0,        32'h0);
    vt[5]  = mk(0, LSU_SZ_H,  32'h1002, 32'h0,        32'h80010000, 0, 32'h1000, 4'b1100, 32'h0,        32'hFFFF8001);
    vt[6]  = mk(0, LSU_SZ_HU, 32'h1002, 32'h0,        32'h80010000, 0, 32'h1000, 4'b1100, 32'h0,        32'h00008001);
    vt[7]  = mk(1, LSU_SZ_W,  32'h2004, 32'hDEADBEEF, 32'h0,        0, 32'h2004, 4'b1111, 32'hDEADBEEF, 32'h0);
    vt[8]  = mk(1, LSU_SZ_H,  32'h2002, 32'hFFFF1234, 32'h0,        0, 32'h2000, 4'b1100, 32'h12340000, 32'h0);
    vt[9]  = mk(0, 3'b111,    32'h1000, 32'h0,        32'h0,        1, 32'h0,    4'b0000, 32'h0,        32'h0);
    vt[10] = mk(1, LSU_SZ_BU, 32'h1000, 32'h0,        32'h0,        1, 32'h0,    4'b0000, 32'h0,        32'h0);
    vt[11] = mk(0, LSU_SZ_W,  32'h3000, 32'h0,        32'h7FFFFFFF, 0, 32'h3000, 4'b1111, 32'h0,        32'h7FFFFFFF);
    vt[12] = mk(0, LSU_SZ_WU, 32'h1000, 32'h0,        32'h0,        1, 32'h0,    4'b0000, 32'h0,        32'h0);
    vt[13] = mk(0, LSU_SZ_H,  32'h1001, 32'h0,        32'h0,        1, 32'h0,    4'b0000, 32'h0,        32'h0);

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_ready", a_req_ready, 1);
    chk("rst_memreq", a_mem_req, 0);
    chk("rst_valid", a_resp_valid, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_be", a_mem_be, 0);
    chk("rst_err", a_resp_err, 0);
    chk("rst_b_ready", b_req_ready, 1);
    chk("rst_b_addr", b_mem_addr, 0);

    for (int i = 0; i < 14; i++) run_a(vt[i], i);

    a_mem_ack = 1'b1; a_mem_rdata = 32'hFFFFFFFF;
    tick();
    a_mem_ack = 1'b0;
    chk("idle_ack_ignored", a_resp_valid, 0);
    chk("idle_ack_noreq", a_mem_req, 0);

    // Wait states: ack in the 4th BUS cycle, then a back-to-back LBU accepted during RESP.
    a_req_valid = 1'b1; a_req_we = 0; a_req_size = LSU_SZ_W; a_req_addr = 32'h2000; a_req_rd = 5'd7;
    tick();
    a_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ws_memreq%0d", i), a_mem_req, 1);
      chk($sformatf("ws_addr%0d", i), a_mem_addr, 32'h2000);
      chk($sformatf("ws_busy%0d", i), a_busy, 1);
      chk($sformatf("ws_novalid%0d", i), a_resp_valid, 0);
      if (i == 3) begin a_mem_ack = 1'b1; a_mem_rdata = 32'h11223344; end
      tick();
    end
    a_mem_ack = 1'b0;
    chk("ws_valid", a_resp_valid, 1);
    chk("ws_rdata", a_resp_rdata, 32'h11223344);
    chk("ws_rd", a_resp_rd, 7);
    chk("ws_memreq_drop", a_mem_req, 0);
    a_req_valid = 1'b1; a_req_size = LSU_SZ_BU; a_req_addr = 32'h2002; a_req_rd = 5'd9;
    tick();
    a_req_valid = 1'b0;
    chk("b2b_memreq", a_mem_req, 1);
    chk("b2b_be", a_mem_be, 4'b0100);
    chk("b2b_single_pulse", a_resp_valid, 0);
    a_mem_ack = 1'b1; a_mem_rdata = 32'h00FF0000;
    tick();
    a_mem_ack = 1'b0;
    chk("b2b_valid", a_resp_valid, 1);
    chk("b2b_rdata", a_resp_rdata, 32'h000000FF);
    chk("b2b_rd", a_resp_rd, 9);
    tick();
    chk("b2b_idle", a_resp_valid, 0);

    // Access with mem_ack held low.
    a_mem_rdata = 32'hA5A5A5A5;
    a_req_valid = 1'b1; a_req_size = LSU_SZ_W; a_req_addr = 32'h3000; a_req_rd = 5'd3;
    tick();
    a_req_valid = 1'b0;
    cnt = 0;
`ifdef CORE_LSU_TIMEOUT_EN
    for (int i = 0; i < 20 && a_mem_req; i++) begin
      cnt++;
      tick();
    end
    chk("to_req_cycles", cnt, 8);
    chk("to_valid", a_resp_valid, 1);
    chk("to_err", a_resp_err, 1);
    chk("to_rdata", a_resp_rdata, 0);
    tick();
    chk("to_idle", a_resp_valid, 0);
`else
    for (int i = 0; i < 20; i++) begin
      if (a_mem_req) cnt++;
      tick();
    end
    chk("wait_req_cycles", cnt, 20);
    chk("wait_no_resp", a_resp_valid, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("wait_rst_ready", a_req_ready, 1);
`endif

    // Reset mid-access on the 64-bit unit, then a late ack.
    b_req_valid = 1'b1; b_req_we = 0; b_req_size = LSU_SZ_D; b_req_addr = 32'h10; b_req_rd = 5'd4;
    tick();
    b_req_valid = 1'b0;
    chk("rm_memreq", b_mem_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rm_memreq_low", b_mem_req, 0);
    chk("rm_valid_low", b_resp_valid, 0);
    b_mem_ack = 1'b1; b_mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    b_mem_ack = 1'b0;
    chk("rm_late_ack_valid", b_resp_valid, 0);
    chk("rm_late_ack_memreq", b_mem_req, 0);
    chk("rm_ready", b_req_ready, 1);

    acc_b("ld8",  0, LSU_SZ_D,  32'h8,  64'h0, 64'h0123456789ABCDEF, 0, 32'h8,  8'hFF, 64'h0,
          64'h0123456789ABCDEF);
    acc_b("lw_c", 0, LSU_SZ_W,  32'hC,  64'h0, 64'h8000000000000000, 0, 32'h8,  8'hF0, 64'h0,
          64'hFFFFFFFF80000000);
    acc_b("lwu_c", 0, LSU_SZ_WU, 32'hC, 64'h0, 64'h8000000000000000, 0, 32'h8,  8'hF0, 64'h0,
          64'h0000000080000000);
    acc_b("sb_1d", 1, LSU_SZ_B, 32'h1D, 64'h5A, 64'h0, 0, 32'h18, 8'h20, 64'h00005A0000000000, 64'h0);
    acc_b("sd_18", 1, LSU_SZ_D, 32'h18, 64'hCAFEF00DDEADBEEF, 64'h0, 0, 32'h18, 8'hFF,
          64'hCAFEF00DDEADBEEF, 64'h0);
    acc_b("ld_mis", 0, LSU_SZ_D, 32'h4, 64'h0, 64'h0, 1, 32'h0, 8'h0, 64'h0, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
